// File: rtl/adc_scan_ctrl.sv
// -----------------------------------------------------------------------------
// adc_scan_ctrl
//
// Periodic channel scheduler for a PCF8591 I2C ADC. Once per sample period it
// walks the enabled analog inputs in ascending order, drives the I2C engine
// through one (or two) read transactions per channel and keeps the latest
// byte per channel in a 4-entry result file. One channel of the result file
// is routed to the display path.
//
// Build option:
//   ADC_SCAN_DISCARD_EN  defined   : two transactions per channel; the first
//                                    byte (stale conversion) is dropped and
//                                    the second one is stored.
//                        undefined : one transaction per channel, stored
//                                    directly (value lags one conversion).
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   en              scan enable
//   ch_mask[3:0]    enabled channels (bit n = AIN n), latched at round start
//   disp_ch[1:0]    channel routed to disp_data
//   i2c_req         one-cycle transaction start pulse
//   i2c_ctrl[7:0]   PCF8591 control byte, stable for the whole transaction
//   i2c_busy        engine busy, holds off i2c_req
//   i2c_done        transaction complete, i2c_rdata valid this cycle
//   i2c_err         NACK / bus fault
//   i2c_rdata[7:0]  byte read from the ADC
//   data_out[7:0]   most recently stored sample
//   data_ch[1:0]    channel of data_out
//   data_valid      one-cycle pulse when a sample is stored
//   disp_data[7:0]  registered result[disp_ch]
//   err             sticky transaction error / timeout flag
//   overrun         sticky flag: sample tick arrived during an active round
// -----------------------------------------------------------------------------
module adc_scan_ctrl #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int SAMPLE_HZ   = 100,
    parameter int TIMEOUT_CYC = 200_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] ch_mask,
    input  logic [1:0] disp_ch,
    output logic       i2c_req,
    output logic [7:0] i2c_ctrl,
    input  logic       i2c_busy,
    input  logic       i2c_done,
    input  logic       i2c_err,
    input  logic [7:0] i2c_rdata,
    output logic [7:0] data_out,
    output logic [1:0] data_ch,
    output logic       data_valid,
    output logic [7:0] disp_data,
    output logic       err,
    output logic       overrun
);

    localparam int P  = CLK_HZ / SAMPLE_HZ;
    localparam int TW = (P > 1) ? $clog2(P) : 1;
    localparam int OW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_STORE,
        S_NEXT
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q;
    logic            tick;
    logic [3:0]      mask_q, mask_d;
    logic [1:0]      ch_q, ch_d;
    logic [OW-1:0]   to_q, to_d;
    logic [7:0]      data_out_q, data_out_d;
    logic [1:0]      data_ch_q, data_ch_d;
    logic [3:0][7:0] result_q, result_d;
    logic [7:0]      disp_q;
    logic            err_q, ovr_q, en_q;
    logic            err_set, en_fall;
`ifdef ADC_SCAN_DISCARD_EN
    logic            pass_q, pass_d;   // 0 = dummy pass, 1 = real pass
`endif

    function automatic logic [1:0] lowest(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign tick    = (tick_cnt_q == TW'(P - 1));
    // Sticky flags clear on the first cycle en is seen low.
    assign en_fall = en_q & ~en;

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        ch_d       = ch_q;
        to_d       = to_q;
        data_out_d = data_out_q;
        data_ch_d  = data_ch_q;
        result_d   = result_q;
        err_set    = 1'b0;
        i2c_req    = 1'b0;
`ifdef ADC_SCAN_DISCARD_EN
        pass_d     = pass_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (tick && en && (ch_mask != 4'd0)) begin
                    mask_d  = ch_mask;
                    ch_d    = lowest(ch_mask);
`ifdef ADC_SCAN_DISCARD_EN
                    pass_d  = 1'b0;
`endif
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!i2c_busy) begin
                    i2c_req = 1'b1;
                    to_d    = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                to_d = to_q + OW'(1);
                // Error beats a simultaneous done: nothing is stored.
                if (i2c_err) begin
                    err_set = 1'b1;
                    state_d = S_NEXT;
                end else if (i2c_done) begin
`ifdef ADC_SCAN_DISCARD_EN
                    if (!pass_q) begin
                        pass_d  = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        data_out_d = i2c_rdata;
                        data_ch_d  = ch_q;
                        state_d    = S_STORE;
                    end
`else
                    data_out_d = i2c_rdata;
                    data_ch_d  = ch_q;
                    state_d    = S_STORE;
`endif
                end else if (to_q == OW'(TIMEOUT_CYC - 1)) begin
                    err_set = 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_STORE: begin
                // data_out_q already holds the byte captured at done.
                result_d[ch_q] = data_out_q;
                state_d        = S_NEXT;
            end
            S_NEXT: begin
                mask_d = mask_q & ~(4'b0001 << ch_q);
                if (!en || (mask_d == 4'd0)) begin
                    state_d = S_IDLE;
                end else begin
                    ch_d    = lowest(mask_d);
`ifdef ADC_SCAN_DISCARD_EN
                    pass_d  = 1'b0;
`endif
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            mask_q     <= '0;
            ch_q       <= '0;
            to_q       <= '0;
            data_out_q <= '0;
            data_ch_q  <= '0;
            result_q   <= '0;
            disp_q     <= '0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
            en_q       <= 1'b0;
`ifdef ADC_SCAN_DISCARD_EN
            pass_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
            mask_q     <= mask_d;
            ch_q       <= ch_d;
            to_q       <= to_d;
            data_out_q <= data_out_d;
            data_ch_q  <= data_ch_d;
            result_q   <= result_d;
            // Read the next-state file so a store shows one cycle after the write.
            disp_q     <= result_d[disp_ch];
            en_q       <= en;
`ifdef ADC_SCAN_DISCARD_EN
            pass_q     <= pass_d;
`endif
            if (en_fall)      err_q <= 1'b0;
            else if (err_set) err_q <= 1'b1;
            if (en_fall)                          ovr_q <= 1'b0;
            else if (tick && state_q != S_IDLE)   ovr_q <= 1'b1;
        end
    end

    assign i2c_ctrl   = {6'b000000, ch_q};
    assign data_out   = data_out_q;
    assign data_ch    = data_ch_q;
    assign data_valid = (state_q == S_STORE);
    assign disp_data  = disp_q;
    assign err        = err_q;
    assign overrun    = ovr_q;

endmodule

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Periodic channel scheduler for the PCF8591 I2C ADC. It sequences the I2C transaction engine through the enabled analog inputs in ascending order, once per sample period. For each channel it writes the control byte, discards the stale first conversion, and stores the fresh byte in a 4-entry result file. It sits between the I2C engine and the 7-segment display path, and drives a selectable channel's value to the display.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `SAMPLE_HZ`, default 100: scan rounds per second. Tick period `P = CLK_HZ/SAMPLE_HZ` cycles; P ≥ 2.
- `TIMEOUT_CYC`, default 200_000: maximum cycles to wait for one transaction to finish.
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `en`  in  1: scan enable.
- `ch_mask`  in  4: enabled channels; bit n = AIN n.
- `disp_ch`  in  2: channel routed to `disp_data`.
- `i2c_req`  out  1: one-cycle transaction start pulse.
- `i2c_ctrl`  out  8: control byte `{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, ch[1:0]}`; held stable from `i2c_req` until the transaction ends.
- `i2c_busy`  in  1: engine busy.
- `i2c_done`  in  1: one-cycle pulse; transaction complete, `i2c_rdata` valid.
- `i2c_err`  in  1: one-cycle pulse; NACK or bus fault.
- `i2c_rdata`  in  8: byte read from the ADC.
- `data_out`  out  8: most recently stored sample.
- `data_ch`  out  2: channel of `data_out`.
- `data_valid`  out  1: one-cycle pulse when a sample is stored.
- `disp_data`  out  8: registered `result[disp_ch]`.
- `err`  out  1: sticky; set on `i2c_err` or timeout.
- `overrun`  out  1: sticky; set when a tick arrives during an active round.

## Operation
- **Reset values:** all outputs 0, `result[0..3]` = 0, state IDLE, tick counter 0.
- **Tick counter:** free-running, counts 0..P-1. `tick` = 1 when count = P-1. Runs regardless of `en`.
- **IDLE:** on `tick` with `en` = 1 and `ch_mask` ≠ 0:
  - latch `ch_mask` into `mask_q`;
  - `ch` ← lowest set bit;
  - go to REQ.
- **Tick during an active round:** round continues, `overrun` ← 1, tick otherwise ignored.
- **REQ:** wait while `i2c_busy` = 1. When it is 0:
  - pulse `i2c_req`;
  - clear timeout counter;
  - go to WAIT.
- **WAIT:** resolve the transaction.
  - `i2c_err`: `err` ← 1, go to NEXT.
  - Timeout counter reaches TIMEOUT_CYC-1 with no `i2c_done`: `err` ← 1, go to NEXT.
  - `i2c_err` and `i2c_done` in the same cycle: error wins and nothing is stored.
  - `i2c_done` on the dummy pass: go to REQ for the second (real) pass on the same channel.
  - `i2c_done` on the real pass: go to STORE.
- **STORE:** `result[ch]` ← `i2c_rdata` (captured at `done`); `data_out`/`data_ch` updated; `data_valid` pulses for one cycle. Then go to NEXT.
- **NEXT:** clear `mask_q[ch]`.
  - If `en` = 0 or `mask_q` is now 0: go to IDLE.
  - Otherwise: `ch` ← next lowest set bit, go to REQ.
- **Error handling:** a failed channel keeps its old result. There is no retry.
- **Enable behaviour:** `en` falling mid-round never aborts an in-flight transaction; the round stops at the next NEXT. `ch_mask` changes mid-round are ignored.
- **Sticky flag clearing:** `err` and `overrun` clear only on `rst`, or on the first cycle `en` = 0.

## Timing
- `i2c_req` is asserted the first cycle in REQ with `i2c_busy` = 0.
- `i2c_ctrl` is valid no later than the `i2c_req` cycle.
- `data_valid` fires 1 cycle after the real-pass `i2c_done`.
- `disp_data` = `result[disp_ch]`, registered.
  - 1-cycle latency from a `disp_ch` change.
  - 1-cycle latency from the `result` write; it reflects a store 2 cycles after `i2c_done`.
- Best-case cycles from tick to first `data_valid` with an ideal engine: REQ, WAIT..., REQ, WAIT..., STORE.
- `rst` mid-transaction returns to reset values on the next edge. The engine must tolerate an abandoned transaction.

## Configuration
- `ADC_SCAN_DISCARD_EN`:
  - **Defined:** two transactions per channel. The first byte (previous conversion) is discarded and only the second is stored.
  - **Undefined:** one transaction per channel. That byte is stored directly; the value lags by one conversion.

## Test plan
Bench parameters: `CLK_HZ`=1000, `SAMPLE_HZ`=100 (P = 10), `TIMEOUT_CYC`=50, `ADC_SCAN_DISCARD_EN` defined. The engine model answers `done` 3 cycles after `req`.

1. **Full scan:** `en`=1, `ch_mask`=4'b1111, model returns {0x11,0xA0} ch0, {0x22,0xA1} ch1, {0x33,0xA2} ch2, {0x44,0xA3} ch3.
   - Required: 8 `req` pulses with ctrl 0x00,0x00,0x01,0x01,0x02,0x02,0x03,0x03.
   - Required: `data_valid` ×4 with `data_out` 0xA0..0xA3 and `data_ch` 0..3.
2. **Sparse mask:** `ch_mask`=4'b1010.
   - Required: only ch1 and ch3 requested; `result[0]` and `result[2]` remain 0.
3. **NACK:** model returns `i2c_err` on ch2's real pass.
   - Required: `err`=1, `result[2]` unchanged, ch3 still scanned and stored.
4. **Timeout:** model never answers on ch0.
   - Required: `err`=1 exactly 50 cycles after `req`, then ch1 is requested.
5. **Overrun and busy:** hold `i2c_busy`=1 for 30 cycles.
   - Required: no `req` while busy; `overrun`=1 after the next tick.
6. **Disable, reset, display:**
   - Drop `en` during ch1 WAIT: ch1 completes, the round ends, `err` and `overrun` clear.
   - Assert `rst`: all outputs 0 on the next edge.
   - `disp_ch`=3 after a scan: `disp_data`=0xA3 one cycle later.
